bus_rr_arbiter: RTL and testbench

BUS_RR_ARBITER -- requirements
Module: bus_rr_arbiter

---
 rtl/bus_rr_arbiter.sv | 152 +++++++++++++++
 tb/tb_bus_rr_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter: four-requester round-robin bus arbiter with a hold limit.
// Each grant lasts until the owner drops its request or MAX_HOLD OWN cycles
// have elapsed. One dead TURN cycle always separates two owners so the
// tri-state enables never overlap. The owner's data is registered onto
// bus_data, and bus_valid qualifies it one cycle later.
//
// Request/grant protocol: a requester holds req[i] high for as long as it
// wants the bus. grant[i] (== oe[i]) is high on every cycle that requester i
// owns the bus. Dropping req[i] ends the tenure at the next edge. Requests
// from non-owners are only looked at in IDLE or TURN.
module bus_rr_arbiter #(
    parameter int N        = 64,
    parameter int MAX_HOLD = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   req,
    input  logic [N-1:0] din0,
    input  logic [N-1:0] din1,
    input  logic [N-1:0] din2,
    input  logic [N-1:0] din3,
    output logic [3:0]   grant,
    output logic [3:0]   oe,
    output logic [1:0]   sel,
    output logic         busy,
    output logic [N-1:0] bus_data,
    output logic         bus_valid,
    output logic [1:0]   state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

    state_t       state, state_n;
    logic [3:0]   grant_n;
    logic [1:0]   sel_n;
    logic [1:0]   ptr, ptr_n;
    logic [7:0]   hold_cnt, hold_n;
    logic         busy_n;
    logic [1:0]   win_idx;
    logic         win_found;
    logic [N-1:0] owner_data;

    // Round-robin search starting at ptr. The loop runs from the farthest
    // offset down to ptr itself, so the closest requester is written last
    // and therefore wins.
    always_comb begin
        logic [1:0] cand;
        win_idx   = ptr;
        win_found = 1'b0;
        cand      = ptr;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr + 2'(k);
            if (req[cand]) begin
                win_idx   = cand;
                win_found = 1'b1;
            end
        end
    end

    // Next-state and next-output logic. All outputs are registered from here.
    always_comb begin
        state_n = state;
        grant_n = grant;
        sel_n   = sel;
        ptr_n   = ptr;
        hold_n  = hold_cnt;
        busy_n  = busy;
        case (state)
            IDLE, TURN: begin
                if (win_found) begin
                    state_n = OWN;
                    grant_n = 4'b0001 << win_idx;
                    sel_n   = win_idx;
                    hold_n  = 8'd1;
                    busy_n  = 1'b1;
                end else begin
                    state_n = IDLE;
                    grant_n = 4'b0000;
                    busy_n  = 1'b0;
                end
            end
            OWN: begin
                if (req[sel] && (hold_cnt < HOLD_MAX)) begin
                    hold_n = hold_cnt + 8'd1;
                end else begin
                    // Voluntary or forced release. The next search starts past the old owner.
                    state_n = TURN;
                    grant_n = 4'b0000;
                    ptr_n   = sel + 2'd1;
                    busy_n  = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = 4'b0000;
                busy_n  = 1'b0;
            end
        endcase
    end

    // Control registers. Reset clears them immediately, which also drops oe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant    <= 4'b0000;
            sel      <= 2'd0;
            ptr      <= 2'd0;
            hold_cnt <= 8'd0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            grant    <= grant_n;
            sel      <= sel_n;
            ptr      <= ptr_n;
            hold_cnt <= hold_n;
            busy     <= busy_n;
        end
    end

    // Owner data select, driven by the registered sel.
    always_comb begin
        case (sel)
            2'd0:    owner_data = din0;
            2'd1:    owner_data = din1;
            2'd2:    owner_data = din2;
            default: owner_data = din3;
        endcase
    end

    // Bus data register. It samples the owner while in OWN and holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_data  <= '0;
            bus_valid <= 1'b0;
        end else begin
            bus_valid <= (state == OWN);
            if (state == OWN) begin
                bus_data <= owner_data;
            end
        end
    end

    assign oe        = grant;
    assign state_dbg = state;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// tb_bus_rr_arbiter: directed test of bus_rr_arbiter.
// Three instances are used. dut_a has MAX_HOLD=16, dut_b has MAX_HOLD=2 and
// dut_c has MAX_HOLD=1. dut_b and dut_c share their request and data inputs.
module tb_bus_rr_arbiter;
    localparam int N = 64;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN  = 2'd1;
    localparam logic [1:0] ST_TURN = 2'd2;

    // Clock and reset.
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n = 1'b1;

    logic [3:0]   req_a = 4'b0000;
    logic [3:0]   req_b = 4'b0000;
    logic [N-1:0] din_a [4];
    logic [N-1:0] din_b [4];

    logic [3:0]   grant_a, oe_a, grant_b, oe_b, grant_c, oe_c;
    logic [1:0]   sel_a, sel_b, sel_c, state_a, state_b, state_c;
    logic         busy_a, busy_b, busy_c;
    logic         bus_valid_a, bus_valid_b, bus_valid_c;
    logic [N-1:0] bus_data_a, bus_data_b, bus_data_c;

    int n_vec = 0;
    int n_err = 0;

    bus_rr_arbiter #(.N(N), .MAX_HOLD(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req_a),
        .din0(din_a[0]), .din1(din_a[1]), .din2(din_a[2]), .din3(din_a[3]),
        .grant(grant_a), .oe(oe_a), .sel(sel_a), .busy(busy_a),
        .bus_data(bus_data_a), .bus_valid(bus_valid_a), .state_dbg(state_a)
    );

    bus_rr_arbiter #(.N(N), .MAX_HOLD(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req_b),
        .din0(din_b[0]), .din1(din_b[1]), .din2(din_b[2]), .din3(din_b[3]),
        .grant(grant_b), .oe(oe_b), .sel(sel_b), .busy(busy_b),
        .bus_data(bus_data_b), .bus_valid(bus_valid_b), .state_dbg(state_b)
    );

    bus_rr_arbiter #(.N(N), .MAX_HOLD(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .req(req_b),
        .din0(din_b[0]), .din1(din_b[1]), .din2(din_b[2]), .din3(din_b[3]),
        .grant(grant_c), .oe(oe_c), .sel(sel_c), .busy(busy_c),
        .bus_data(bus_data_c), .bus_valid(bus_valid_c), .state_dbg(state_c)
    );

    // Single comparison point.
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic [3:0] g, input logic [3:0] o,
                           input logic [1:0] s, input logic b, input logic [1:0] st,
                           input logic [3:0] eg, input logic [1:0] es, input logic eb,
                           input logic [1:0] est);
        check({tag, "_grant"}, 64'(g), 64'(eg));
        check({tag, "_oe"}, 64'(o), 64'(eg));
        check({tag, "_sel"}, 64'(s), 64'(es));
        check({tag, "_busy"}, 64'(b), 64'(eb));
        check({tag, "_state"}, 64'(st), 64'(est));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Contention monitor. At most one enable may be high, and oe may never
    // jump from one owner straight to a different owner.
    logic [3:0] prev_a = 4'b0000;
    logic [3:0] prev_b = 4'b0000;
    logic [3:0] prev_c = 4'b0000;

    function automatic logic oe_ok(input logic [3:0] cur, input logic [3:0] prev);
        return ($countones(cur) <= 1) && !((prev != 4'b0) && (cur != 4'b0) && (cur != prev));
    endfunction

    always @(negedge clk) begin
        check("contention_a", 64'(oe_ok(oe_a, prev_a)), 64'd1);
        check("contention_b", 64'(oe_ok(oe_b, prev_b)), 64'd1);
        check("contention_c", 64'(oe_ok(oe_c, prev_c)), 64'd1);
        prev_a = oe_a;
        prev_b = oe_b;
        prev_c = oe_c;
    end

    initial begin
        int ph;
        int ow;
        din_a[0] = 64'h1111_0000_0000_0A00;
        din_a[1] = 64'h0000_0000_0000_00A5;
        din_a[2] = 64'hDEAD_BEEF_0000_0002;
        din_a[3] = 64'h3333_3333_3333_3333;
        din_b[0] = 64'h0000_0000_0000_00B0;
        din_b[1] = 64'h0000_0000_0000_00B1;
        din_b[2] = 64'h0000_0000_0000_00B2;
        din_b[3] = 64'h0000_0000_0000_00B3;

        // Asynchronous reset takes effect without a clock edge.
        #1 rst_n = 1'b0;
        #1;
        chk_ctl("rst_a", grant_a, oe_a, sel_a, busy_a, state_a, 4'b0000, 2'd0, 1'b0, ST_IDLE);
        chk_ctl("rst_b", grant_b, oe_b, sel_b, busy_b, state_b, 4'b0000, 2'd0, 1'b0, ST_IDLE);
        check("rst_a_valid", 64'(bus_valid_a), 64'd0);
        check("rst_a_data", bus_data_a, 64'd0);
        check("rst_c_valid", 64'(bus_valid_c), 64'd0);
        repeat (2) tick();
        chk_ctl("rst_hold_a", grant_a, oe_a, sel_a, busy_a, state_a, 4'b0000, 2'd0, 1'b0, ST_IDLE);
        @(negedge clk);
        rst_n = 1'b1;

        // Single request held for five edges, then released.
        req_a = 4'b0010;
        for (int e = 1; e <= 5; e++) begin
            tick();
            chk_ctl($sformatf("s1_e%0d", e), grant_a, oe_a, sel_a, busy_a, state_a,
                    4'b0010, 2'd1, 1'b1, ST_OWN);
            check($sformatf("s1_e%0d_valid", e), 64'(bus_valid_a), (e >= 2) ? 64'd1 : 64'd0);
            check($sformatf("s1_e%0d_data", e), bus_data_a, (e >= 2) ? 64'hA5 : 64'd0);
        end
        req_a = 4'b0000;
        tick();
        chk_ctl("s1_turn", grant_a, oe_a, sel_a, busy_a, state_a, 4'b0000, 2'd1, 1'b1, ST_TURN);
        check("s1_turn_valid", 64'(bus_valid_a), 64'd1);
        check("s1_turn_data", bus_data_a, 64'hA5);
        tick();
        chk_ctl("s1_idle", grant_a, oe_a, sel_a, busy_a, state_a, 4'b0000, 2'd1, 1'b0, ST_IDLE);
        check("s1_idle_valid", 64'(bus_valid_a), 64'd0);
        check("s1_idle_data", bus_data_a, 64'hA5);

        // A sole requester is forced off after 16 cycles and regains the bus after one TURN.
        req_a = 4'b0100;
        for (int r = 0; r < 2; r++) begin
            for (int k = 1; k <= 16; k++) begin
                tick();
                chk_ctl($sformatf("s3_r%0d_k%0d", r, k), grant_a, oe_a, sel_a, busy_a, state_a,
                        4'b0100, 2'd2, 1'b1, ST_OWN);
                if (k == 2) check($sformatf("s3_r%0d_data", r), bus_data_a, din_a[2]);
            end
            tick();
            chk_ctl($sformatf("s3_r%0d_turn", r), grant_a, oe_a, sel_a, busy_a, state_a,
                    4'b0000, 2'd2, 1'b1, ST_TURN);
        end
        tick();
        chk_ctl("s3_regain", grant_a, oe_a, sel_a, busy_a, state_a, 4'b0100, 2'd2, 1'b1, ST_OWN);
        req_a = 4'b0000;
        repeat (2) tick();
        chk_ctl("s3_idle", grant_a, oe_a, sel_a, busy_a, state_a, 4'b0000, 2'd2, 1'b0, ST_IDLE);

        // With ptr=3, the search wraps so that 0 wins. Requester 2 is ignored and wins after release.
        req_a = 4'b0101;
        tick();
        chk_ctl("s4_win0", grant_a, oe_a, sel_a, busy_a, state_a, 4'b0001, 2'd0, 1'b1, ST_OWN);
        tick();
        chk_ctl("s4_hold0", grant_a, oe_a, sel_a, busy_a, state_a, 4'b0001, 2'd0, 1'b1, ST_OWN);
        req_a = 4'b0100;
        tick();
        chk_ctl("s4_turn", grant_a, oe_a, sel_a, busy_a, state_a, 4'b0000, 2'd0, 1'b1, ST_TURN);
        tick();
        chk_ctl("s4_win2", grant_a, oe_a, sel_a, busy_a, state_a, 4'b0100, 2'd2, 1'b1, ST_OWN);
        req_a = 4'b0000;
        repeat (2) tick();

        // All four request. Each owner gets MAX_HOLD OWN cycles, then one TURN cycle.
        req_b = 4'b1111;
        for (int e = 0; e < 13; e++) begin
            tick();
            ph = e % 3;
            ow = (e / 3) % 4;
            chk_ctl($sformatf("s2_b_e%0d", e), grant_b, oe_b, sel_b, busy_b, state_b,
                    (ph < 2) ? (4'b0001 << ow) : 4'b0000, 2'(ow), 1'b1,
                    (ph < 2) ? ST_OWN : ST_TURN);
            if (e >= 1 && ((e - 1) % 3) < 2) begin
                check($sformatf("s2_b_e%0d_valid", e), 64'(bus_valid_b), 64'd1);
                check($sformatf("s2_b_e%0d_data", e), bus_data_b, din_b[((e - 1) / 3) % 4]);
            end else begin
                check($sformatf("s2_b_e%0d_valid", e), 64'(bus_valid_b), 64'd0);
            end
            ph = e % 2;
            ow = (e / 2) % 4;
            chk_ctl($sformatf("s2_c_e%0d", e), grant_c, oe_c, sel_c, busy_c, state_c,
                    (ph == 0) ? (4'b0001 << ow) : 4'b0000, 2'(ow), 1'b1,
                    (ph == 0) ? ST_OWN : ST_TURN);
        end
        req_b = 4'b0000;
        repeat (2) tick();

        // Asynchronous reset in the middle of requester 3's ownership.
        req_a = 4'b1000;
        tick();
        chk_ctl("s5_own3", grant_a, oe_a, sel_a, busy_a, state_a, 4'b1000, 2'd3, 1'b1, ST_OWN);
        tick();
        #3 rst_n = 1'b0;
        #1;
        chk_ctl("s5_rst", grant_a, oe_a, sel_a, busy_a, state_a, 4'b0000, 2'd0, 1'b0, ST_IDLE);
        check("s5_rst_valid", 64'(bus_valid_a), 64'd0);
        check("s5_rst_data", bus_data_a, 64'd0);
        tick();
        chk_ctl("s5_rst_hold", grant_a, oe_a, sel_a, busy_a, state_a, 4'b0000, 2'd0, 1'b0, ST_IDLE);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_ctl("s5_first", grant_a, oe_a, sel_a, busy_a, state_a, 4'b1000, 2'd3, 1'b1, ST_OWN);
        tick();
        check("s5_valid", 64'(bus_valid_a), 64'd1);
        check("s5_data", bus_data_a, din_a[3]);
        req_a = 4'b0000;
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
